psum_ofifo: RTL
===============

Name: psum_ofifo

Overview:
- Output-side collector for the MAC array.
- Captures per-column partial sums that the array writes at staggered, column-skewed times using its per-column fifo_wr strobes.
- Presents them downstream as column-aligned rows of col psums.
- Downstream logic (psum SRAM writer / accumulator) pops one full row per read.

Parameters:
col, 8, number of MAC columns (independent FIFO lanes)
bw_psum, 22, width of one partial sum in bits
depth, 16, entries per lane; power of two, >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr  input  col  per-lane write strobe; bit i pushes lane i (driven by MAC array fifo_wr)
in  input  col*bw_psum  packed psums; lane i at bits [(i+1)*bw_psum-1 : i*bw_psum]
rd  input  1  row pop request
out  output  col*bw_psum  registered popped row, same packing as in
o_valid  output  1  every lane non-empty; a row is available to pop
o_full  output  1  at least one lane is full
o_ready  output  1  equals ~o_full
overflow  output  1  sticky; a write hit a full lane and was dropped
underflow  output  1  sticky; rd asserted while o_valid=0

Behaviour:
- Storage: col lanes of depth x bw_psum.
  - Each lane has its own write pointer of log2(depth)+1 bits (extra wrap bit).
  - All lanes share one read pointer of the same width.
  - Per-lane empty: wptr_i == rptr.
  - Per-lane full: addresses equal and wrap bits differ.
  - Pointers wrap modulo 2*depth; addresses wrap modulo depth.
- o_valid, o_full and o_ready are combinational from the pointers.
- Push: on a rising edge with wr[i]=1, lane i stores its in slice at its write address and increments its pointer.
  - Each lane is independent; any subset of lanes may push in the same cycle.
- Pop accepted when rd=1 and o_valid=1 at the edge.
  - out <= row at read address (all lanes); rptr increments.
  - Latency: out is valid on the cycle after the accepting edge.
  - out holds its value until the next accepted pop.
- Push to a lane that is full at the edge:
  - If a pop is accepted in the same cycle, the push is accepted (slot freed; lane count unchanged).
  - Otherwise the push is dropped, the pointer is unchanged, and overflow is set.
- Push to an empty lane together with rd:
  - The pop is rejected (o_valid evaluated before the edge); the push completes.
  - underflow is set, since o_valid=0.
- rd with o_valid=0: no pointer or out change; underflow is set.
- Simultaneous pop and pushes on non-full lanes: both take effect; per-lane count = old + wr[i] - 1.
- overflow and underflow clear only on reset.
- No internal state machine beyond pointers; the fill state per lane is fully defined by wptr_i - rptr.
- Reset (synchronous, wins over all other activity, including mid-burst):
  - All pointers = 0, out = 0, overflow = 0, underflow = 0.
  - Result: o_valid = 0, o_full = 0, o_ready = 1.
  - Storage contents are don't-care.
  - Any wr/rd in the reset cycle is ignored.

Test Plan:
- Reset then idle -> out=0, o_valid=0, o_full=0, o_ready=1, overflow=0, underflow=0.
- Diagonal fill: push lane i with value 100+i at cycle i (i=0..7), one lane per cycle.
  - o_valid stays 0 until the edge writing lane 7, then goes 1.
  - rd pulse: out lanes = 100..107 one cycle later; o_valid returns to 0.
- Fill: write all lanes 16 times with row index k (lane value = 16*k+i).
  - o_full=1 after the 16th write.
  - 17th write dropped: overflow=1.
  - 16 pops return k=0..15 in order, across the pointer wrap; then o_valid=0.
- Full with simultaneous rd and wr=all-ones:
  - Pop returns the oldest row; new row accepted; o_full stays 1; overflow stays 0.
- rd on empty FIFO -> underflow=1, out unchanged, pointers unchanged.
  - Next, write one row and pop it; data is correct.
- Reset mid-operation: 5 rows buffered, then reset with wr and rd high.
  - Next cycle: o_valid=0, out=0, flags=0.
  - A subsequent single-row push/pop returns the new data, not stale rows.

Source files
------------

// File: rtl/psum_ofifo.sv
// Output-side psum collector: one FIFO lane per MAC column, written at skewed
// times, popped as a column-aligned row through a shared read pointer.

module psum_ofifo_lane #(
  parameter int bw    = 22,
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   pop,
  input  logic [bw-1:0]          din,
  input  logic [$clog2(depth):0] rptr,
  output logic [bw-1:0]          rdata,
  output logic                   empty,
  output logic                   full,
  output logic                   drop
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr;
  logic [bw-1:0] mem [depth];
  logic          push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  // A full lane still accepts a write when the same edge pops a row and frees its slot.
  assign push  = wr & (~full | pop);
  assign drop  = wr & full & ~pop;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) wptr <= '0;
    else if (push) wptr <= wptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr[AW-1:0]] <= din;
  end
endmodule

module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [PW-1:0]                  rptr;
  logic [col-1:0][bw_psum-1:0]    din, rdata;
  logic [col-1:0]                 empty, full, drop;
  logic                           pop;

  assign din     = in;
  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_ofifo_lane #(.bw(bw_psum), .depth(depth)) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .pop   (pop),
      .din   (din[i]),
      .rptr  (rptr),
      .rdata (rdata[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .drop  (drop[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr      <= '0;
      out       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop) begin
        out  <= rdata;
        rptr <= rptr + PW'(1);
      end
      if (|drop)         overflow  <= 1'b1;
      if (rd && !o_valid) underflow <= 1'b1;
    end
  end
endmodule
